// File: rtl/capture_sequencer.sv
// capture_sequencer: gates a finite, optionally decimated run of 32-bit samples
// into the read FIFO. It counts kept samples, records drops when the FIFO is
// full, and raises the stream EOF once the capture has ended and the host has
// drained the FIFO.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | no capture running; waiting for a start strobe
//   ST_CAPTURE | writing kept samples; remaining counts down per kept sample
//   ST_DONE    | capture finished or aborted; EOF once the FIFO is empty
module capture_sequencer #(
    parameter int COUNT_W = 24
) (
    input  logic               bus_clk_i,
    input  logic               srst_i,
    input  logic               cfg_start_i,
    input  logic               cfg_abort_i,
    input  logic [COUNT_W-1:0] cfg_count_i,
    input  logic [COUNT_W-1:0] cfg_decim_i,
    input  logic               sample_valid_i,
    input  logic [31:0]        sample_data_i,
    input  logic               fifo_full_i,
    input  logic               fifo_empty_i,
    output logic               fifo_wr_en_o,
    output logic [31:0]        fifo_din_o,
    input  logic               stream_open_i,
    output logic               stream_eof_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               overflow_o,
    output logic [COUNT_W-1:0] drop_count_o,
    output logic [COUNT_W-1:0] remaining_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam logic [COUNT_W-1:0] ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] remaining_q, remaining_d;
    logic [COUNT_W-1:0] decim_q, decim_d;
    logic [COUNT_W-1:0] phase_q, phase_d;
    logic [COUNT_W-1:0] drop_count_q, drop_count_d;
    logic               done_q, done_d;
    logic               overflow_q, overflow_d;
    logic               wr_en;
    logic               kept;

    // State and status registers; reset returns everything to idle and clear.
    always_ff @(posedge bus_clk_i) begin
        if (srst_i) begin
            state_q      <= ST_IDLE;
            remaining_q  <= '0;
            decim_q      <= '0;
            phase_q      <= '0;
            drop_count_q <= '0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            decim_q      <= decim_d;
            phase_q      <= phase_d;
            drop_count_q <= drop_count_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
        end
    end

    // Next-state, counter updates and the zero-latency FIFO write decision.
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        decim_d      = decim_q;
        phase_d      = phase_q;
        drop_count_d = drop_count_q;
        done_d       = done_q;
        overflow_d   = overflow_q;
        wr_en        = 1'b0;
        kept         = (phase_q == '0);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (cfg_start_i) begin
                    // A start always begins a fresh capture record, even an
                    // empty one that goes straight to DONE.
                    overflow_d   = 1'b0;
                    drop_count_d = '0;
                    phase_d      = '0;
                    if (stream_open_i && (cfg_count_i != '0)) begin
                        state_d     = ST_CAPTURE;
                        remaining_d = cfg_count_i;
                        decim_d     = cfg_decim_i;
                        done_d      = 1'b0;
                    end else begin
                        state_d     = ST_DONE;
                        remaining_d = '0;
                        done_d      = 1'b1;
                    end
                end else if ((state_q == ST_DONE) && !stream_open_i) begin
                    state_d = ST_IDLE;
                end
            end

            ST_CAPTURE: begin
                if (cfg_abort_i) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (!stream_open_i) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (sample_valid_i) begin
                    phase_d = (phase_q == decim_q) ? '0 : phase_q + ONE;
                    if (kept) begin
                        if (fifo_full_i) begin
                            overflow_d = 1'b1;
                            if (drop_count_q != '1) begin
                                drop_count_d = drop_count_q + ONE;
                            end
                        end else begin
                            wr_en = 1'b1;
                        end
                        // Slots are consumed whether written or dropped so the
                        // capture length never depends on host drain speed.
                        remaining_d = remaining_q - ONE;
                        if (remaining_q == ONE) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A reset cycle must never leak a write, so the enable is masked by srst.
    assign fifo_wr_en_o = wr_en & ~srst_i;
    assign fifo_din_o   = sample_data_i;
    assign stream_eof_o = (state_q == ST_DONE) && stream_open_i && fifo_empty_i;
    assign busy_o       = (state_q == ST_CAPTURE);
    assign done_o       = done_q;
    assign overflow_o   = overflow_q;
    assign drop_count_o = drop_count_q;
    assign remaining_o  = remaining_q;

endmodule
